fwd_sel_gen: RTL and testbench
==============================

# fwd_sel_gen

Forwarding and load-use hazard controller for the 5-stage MIPS pipeline. It tracks destination registers of in-flight instructions in its own shadow EX/MEM/WB registers. It produces the 2-bit operand selects consumed by the EX-stage 3:1 operand muxes: 0 = register-file value, 1 = EX/MEM result, 2 = MEM/WB result. It also raises a one-cycle stall for load-use hazards and keeps a saturating stall counter for performance monitoring.

## Interface
Parameters:
- REG_W, 5, register-index width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs  in  REG_W  source register A of decode instruction
- id_rt  in  REG_W  source register B of decode instruction
- id_uses_rt  in  1  decode instruction reads rt as a source; stores and R-type set it, I-type ALU and loads clear it
- id_dst  in  REG_W  destination register of decode instruction
- id_we  in  1  decode instruction writes the register file
- id_is_load  in  1  decode instruction is a load
- flush  in  1  kill the decode instruction (taken branch/jump)
- ex_sel_a  out  2  operand-A select for the EX instruction
- ex_sel_b  out  2  operand-B select for the EX instruction
- stall  out  1  hold PC and IF/ID this cycle; a bubble enters EX
- stall_count  out  CNT_W  number of stall cycles since reset, saturating

## Operation
- Shadow stage registers:
  - EX: {valid, we, is_load, dst, rs, rt, uses_rt}
  - MEM: {valid, we, is_load, dst}
  - WB: {valid, we, dst}
- "Writer" in a stage = valid & we & dst != 0. Register 0 is never forwarded and never causes a stall.
- stall (combinational) = id_valid & ~flush & EX is a writer & EX.is_load & (id_rs == EX.dst | (id_uses_rt & id_rt == EX.dst)).
- Stage advance, every cycle unless rst:
  - Normal: EX <= ID fields with valid = id_valid & ~flush; MEM <= EX; WB <= MEM.
  - stall = 1: EX <= bubble (valid = 0); MEM <= EX; WB <= MEM. The ID instruction is re-presented by the CPU next cycle.
  - flush = 1: EX receives a bubble. flush suppresses stall.
- ex_sel_a (combinational from state):
  - 1 if MEM is a writer, MEM.dst == EX.rs, and MEM is not a load
  - else 2 if WB is a writer and WB.dst == EX.rs
  - else 0
  - MEM priority over WB: the newest value wins.
- ex_sel_b: same rule against EX.rt, gated by EX.uses_rt; 0 when uses_rt = 0.
- A load in MEM matching an EX source cannot occur, because stall prevents it. If it is presented anyway, select 0. Value 3 is never driven.
- When EX.valid = 0, both selects are 0.
- stall_count increments on each cycle where stall = 1 and holds at all-ones (saturates).

## Timing
- Reset: all valid bits 0; ex_sel_a = ex_sel_b = 0, stall = 0, stall_count = 0 in the cycle after rst is sampled high. Reset mid-stall discards all in-flight state.
- Selects and stall are combinational from registered state plus ID inputs; no added latency. Selects are valid in the same cycle the instruction occupies EX.
- A load-use hazard costs exactly one stall cycle. In the following cycle the load is in WB and the consumer in EX gets sel = 2.
- Back-to-back dependent ALU ops: consumer sees sel = 1 on the first EX cycle with no stall.
- Simultaneous MEM and WB match on the same register: sel = 1.

## Test plan
- Reset: assert rst for 2 cycles with random ID inputs -> selects 0, stall 0, stall_count 0.
- Dependency chains:
  - add $3 <- $1,$2 then sub $4 <- $3,$5 -> second op in EX has ex_sel_a = 1, ex_sel_b = 0, stall never 1.
  - Same producer with one independent op between -> consumer has ex_sel_a = 2.
- Load-use: lw $8 then add $9 <- $7,$8 (uses_rt = 1) -> stall = 1 for exactly one cycle, stall_count = 1; consumer then in EX with ex_sel_b = 2, ex_sel_a = 0.
- Register 0 and flush:
  - Producer writing $0 followed by a reader of $0 -> all selects 0, no stall.
  - Load-use pair with flush = 1 on the consumer -> stall = 0; next EX valid = 0.
- Priority and select gating:
  - Two writers of $6 back-to-back, then a reader of $6 -> ex_sel_a = 1 (MEM wins).
  - I-type reader with uses_rt = 0 whose id_rt matches MEM.dst -> ex_sel_b = 0.
- Counter saturation: with CNT_W = 4, force 20 load-use stalls -> stall_count holds at 15.

Source files
------------

// File: rtl/fwd_sel_gen.sv
// fwd_sel_gen: forwarding-select and load-use stall generator for a
// 5-stage pipeline. Keeps its own copy of the EX/MEM/WB destination state
// and drives the EX operand mux selects (0 = regfile, 1 = EX/MEM,
// 2 = MEM/WB), a one-cycle load-use stall, and a saturating stall counter.
module fwd_sel_gen #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             flush,
    output logic [1:0]       ex_sel_a,
    output logic [1:0]       ex_sel_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    // EX shadow stage
    logic             ex_valid_reg;
    logic             ex_we_reg;
    logic             ex_is_load_reg;
    logic [REG_W-1:0] ex_dst_reg;
    logic [REG_W-1:0] ex_rs_reg;
    logic [REG_W-1:0] ex_rt_reg;
    logic             ex_uses_rt_reg;

    // MEM shadow stage
    logic             mem_valid_reg;
    logic             mem_we_reg;
    logic             mem_is_load_reg;
    logic [REG_W-1:0] mem_dst_reg;

    // WB shadow stage
    logic             wb_valid_reg;
    logic             wb_we_reg;
    logic [REG_W-1:0] wb_dst_reg;

    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] stall_count_next;

    logic             ex_writer;
    logic             mem_writer;
    logic             wb_writer;
    logic             rs_hit;
    logic             rt_hit;
    logic             issue_valid;

    // Register 0 is hard-wired zero, so a stage writing it is not a producer.
    assign ex_writer  = ex_valid_reg  & ex_we_reg  & (ex_dst_reg  != '0);
    assign mem_writer = mem_valid_reg & mem_we_reg & (mem_dst_reg != '0);
    assign wb_writer  = wb_valid_reg  & wb_we_reg  & (wb_dst_reg  != '0);

    // Load-use hazard: the decode instruction needs a load result that is
    // still one stage away from being forwardable.
    assign rs_hit      = (id_rs == ex_dst_reg);
    assign rt_hit      = id_uses_rt & (id_rt == ex_dst_reg);
    assign stall       = id_valid & ~flush & ex_writer & ex_is_load_reg & (rs_hit | rt_hit);
    assign issue_valid = id_valid & ~flush & ~stall;

    // Source operands of the EX instruction, index 0 = A (rs), 1 = B (rt).
    logic [1:0][REG_W-1:0] ex_src;
    logic [1:0]            src_used;
    logic [1:0][1:0]       sel;

    assign ex_src[0]   = ex_rs_reg;
    assign ex_src[1]   = ex_rt_reg;
    assign src_used[0] = 1'b1;
    assign src_used[1] = ex_uses_rt_reg;

    // Newest producer wins: MEM beats WB. A load still in MEM cannot supply
    // its value yet, so that case falls back to the register file.
    function automatic logic [1:0] fwd_sel(
        input logic             ex_v,
        input logic             used,
        input logic [REG_W-1:0] src,
        input logic             mem_w,
        input logic             mem_ld,
        input logic [REG_W-1:0] mem_d,
        input logic             wb_w,
        input logic [REG_W-1:0] wb_d
    );
        logic [1:0] r;
        r = 2'd0;
        if (ex_v && used) begin
            if (mem_w && (mem_d == src)) begin
                r = mem_ld ? 2'd0 : 2'd1;
            end else if (wb_w && (wb_d == src)) begin
                r = 2'd2;
            end
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sel
            assign sel[gi] = fwd_sel(ex_valid_reg, src_used[gi], ex_src[gi],
                                     mem_writer, mem_is_load_reg, mem_dst_reg,
                                     wb_writer, wb_dst_reg);
        end
    endgenerate

    assign ex_sel_a    = sel[0];
    assign ex_sel_b    = sel[1];
    assign stall_count = stall_count_reg;

    // Saturating count of stall cycles.
    always_comb begin
        stall_count_next = stall_count_reg;
        if (stall && (stall_count_reg != '1)) begin
            stall_count_next = stall_count_reg + 1'b1;
        end
    end

    // Pipeline advance: EX takes decode (or a bubble on stall/flush),
    // MEM and WB always shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg    <= 1'b0;
            ex_we_reg       <= 1'b0;
            ex_is_load_reg  <= 1'b0;
            ex_dst_reg      <= '0;
            ex_rs_reg       <= '0;
            ex_rt_reg       <= '0;
            ex_uses_rt_reg  <= 1'b0;
            mem_valid_reg   <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_is_load_reg <= 1'b0;
            mem_dst_reg     <= '0;
            wb_valid_reg    <= 1'b0;
            wb_we_reg       <= 1'b0;
            wb_dst_reg      <= '0;
            stall_count_reg <= '0;
        end else begin
            ex_valid_reg    <= issue_valid;
            ex_we_reg       <= id_we;
            ex_is_load_reg  <= id_is_load;
            ex_dst_reg      <= id_dst;
            ex_rs_reg       <= id_rs;
            ex_rt_reg       <= id_rt;
            ex_uses_rt_reg  <= id_uses_rt;
            mem_valid_reg   <= ex_valid_reg;
            mem_we_reg      <= ex_we_reg;
            mem_is_load_reg <= ex_is_load_reg;
            mem_dst_reg     <= ex_dst_reg;
            wb_valid_reg    <= mem_valid_reg;
            wb_we_reg       <= mem_we_reg;
            wb_dst_reg      <= mem_dst_reg;
            stall_count_reg <= stall_count_next;
        end
    end

endmodule

// File: tb/tb_fwd_sel_gen.sv
// Testbench for fwd_sel_gen: directed pipeline scenarios with literal
// expectations, then randomized traffic checked every cycle against an
// instruction-history reference model.
module tb_fwd_sel_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_uses_rt = 1'b0;
    logic [4:0] id_dst = '0;
    logic       id_we = 1'b0;
    logic       id_is_load = 1'b0;
    logic       flush = 1'b0;

    logic [1:0]  sel_a, sel_b, sel_a4, sel_b4;
    logic        stall, stall4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_sel_gen #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .ex_sel_a(sel_a),
        .ex_sel_b(sel_b), .stall(stall), .stall_count(cnt)
    );

    fwd_sel_gen #(.REG_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .ex_sel_a(sel_a4),
        .ex_sel_b(sel_b4), .stall(stall4), .stall_count(cnt4)
    );

    // ---------------- reference model: last three issued instructions ----
    typedef struct packed {
        logic       v;
        logic       we;
        logic       ld;
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;
    int   m_cnt  = 0;
    int   m_cnt4 = 0;
    bit   m_ok   = 0;

    function automatic bit is_writer(ins_t s);
        return s.v && s.we && (s.dst != 5'd0);
    endfunction

    function automatic logic [1:0] exp_sel(logic [4:0] r, logic used);
        if (!m_ex.v || !used) return 2'd0;
        if (is_writer(m_mem) && m_mem.dst == r) return m_mem.ld ? 2'd0 : 2'd1;
        if (is_writer(m_wb) && m_wb.dst == r) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit exp_stall();
        return id_valid && !flush && is_writer(m_ex) && m_ex.ld &&
               (id_rs == m_ex.dst || (id_uses_rt && id_rt == m_ex.dst));
    endfunction

    always @(posedge clk) begin
        bit   st;
        ins_t nw;
        if (rst) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
            m_cnt = 0; m_cnt4 = 0; m_ok = 1;
        end else begin
            st = exp_stall();
            if (st) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            nw.v  = id_valid && !flush && !st;
            nw.we = id_we; nw.ld = id_is_load; nw.dst = id_dst;
            nw.rs = id_rs; nw.rt = id_rt; nw.ur = id_uses_rt;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = nw;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("sel_a",  32'(sel_a),  32'(exp_sel(m_ex.rs, 1'b1)));
            chk("sel_b",  32'(sel_b),  32'(exp_sel(m_ex.rt, m_ex.ur)));
            chk("stall",  32'(stall),  32'(exp_stall()));
            chk("count",  32'(cnt),    32'(m_cnt));
            chk("sel_a4", 32'(sel_a4), 32'(exp_sel(m_ex.rs, 1'b1)));
            chk("sel_b4", 32'(sel_b4), 32'(exp_sel(m_ex.rt, m_ex.ur)));
            chk("stall4", 32'(stall4), 32'(exp_stall()));
            chk("count4", 32'(cnt4),   32'(m_cnt4));
        end
    end

    // Present one decode slot, then return at the following falling edge.
    task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic [4:0] dst, input logic we,
                       input logic ld, input logic fl);
        @(posedge clk);
        #1;
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ur;
        id_dst = dst; id_we = we; id_is_load = ld; flush = fl;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_id();
        id_valid = 1'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
        id_uses_rt = 1'($urandom); id_dst = 5'($urandom); id_we = 1'($urandom);
        id_is_load = 1'($urandom); flush = 1'($urandom);
    endtask

    initial begin
        bit st_prev;

        // Reset for two cycles with random decode inputs.
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            rand_id();
        end
        @(negedge clk);
        chk("rst_sel_a", 32'(sel_a), 0);
        chk("rst_sel_b", 32'(sel_b), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_count", 32'(cnt), 0);
        rst = 1'b0;
        idle(3);

        // Load-use: lw $8 ; add $9 <- $7,$8
        cyc(1, 4, 8, 0, 8, 1, 1, 0);
        cyc(1, 7, 8, 1, 9, 1, 0, 0);
        chk("lu_stall_on", 32'(stall), 1);
        cyc(1, 7, 8, 1, 9, 1, 0, 0);
        chk("lu_stall_off", 32'(stall), 0);
        chk("lu_count", 32'(cnt), 1);
        idle(1);
        chk("lu_sel_a", 32'(sel_a), 0);
        chk("lu_sel_b", 32'(sel_b), 2);

        // Back-to-back ALU dependency: add $3 ; sub $4 <- $3,$5
        idle(3);
        cyc(1, 1, 2, 1, 3, 1, 0, 0);
        cyc(1, 3, 5, 1, 4, 1, 0, 0);
        chk("b2b_stall", 32'(stall), 0);
        idle(1);
        chk("b2b_sel_a", 32'(sel_a), 1);
        chk("b2b_sel_b", 32'(sel_b), 0);

        // One independent op between producer and consumer.
        idle(3);
        cyc(1, 1, 2, 1, 3, 1, 0, 0);
        cyc(1, 10, 11, 1, 12, 1, 0, 0);
        cyc(1, 3, 5, 1, 4, 1, 0, 0);
        idle(1);
        chk("gap_sel_a", 32'(sel_a), 2);
        chk("gap_sel_b", 32'(sel_b), 0);

        // Register 0 is never forwarded and never stalls.
        idle(3);
        cyc(1, 1, 2, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 5, 1, 0, 0);
        idle(1);
        chk("r0_sel_a", 32'(sel_a), 0);
        chk("r0_sel_b", 32'(sel_b), 0);
        cyc(1, 1, 0, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 1, 5, 1, 0, 0);
        chk("r0_ld_stall", 32'(stall), 0);

        // Flush suppresses the load-use stall and leaves a bubble in EX.
        idle(3);
        cyc(1, 4, 8, 0, 8, 1, 1, 0);
        cyc(1, 7, 8, 1, 9, 1, 0, 1);
        chk("fl_stall", 32'(stall), 0);
        idle(1);
        chk("fl_sel_a", 32'(sel_a), 0);
        chk("fl_sel_b", 32'(sel_b), 0);

        // Two writers of $6 back-to-back: MEM copy wins.
        idle(3);
        cyc(1, 1, 2, 1, 6, 1, 0, 0);
        cyc(1, 2, 3, 1, 6, 1, 0, 0);
        cyc(1, 6, 6, 1, 7, 1, 0, 0);
        idle(1);
        chk("pri_sel_a", 32'(sel_a), 1);
        chk("pri_sel_b", 32'(sel_b), 1);

        // I-type reader: rt matches MEM.dst but is not a source.
        idle(3);
        cyc(1, 1, 2, 1, 7, 1, 0, 0);
        cyc(1, 1, 7, 0, 8, 1, 0, 0);
        idle(1);
        chk("irt_sel_a", 32'(sel_a), 0);
        chk("irt_sel_b", 32'(sel_b), 0);

        // Twenty load-use stalls: 4-bit counter saturates.
        for (int i = 0; i < 20; i++) begin
            cyc(1, 4, 8, 0, 8, 1, 1, 0);
            cyc(1, 7, 8, 1, 9, 1, 0, 0);
            cyc(1, 7, 8, 1, 9, 1, 0, 0);
        end
        chk("sat_count4", 32'(cnt4), 15);
        chk("sat_count16", 32'(cnt), 21);

        // Randomized traffic; a stalled instruction is re-presented.
        st_prev = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (st_prev) begin
                cyc(id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_we, id_is_load, 1'b0);
            end else begin
                cyc(1'($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 9) == 0));
            end
            st_prev = exp_stall();
        end
        rst = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
